fpu_norm_ls16: RTL

//  Left-shift normalizer for 16-bit FPU mantissas. It is the counterpart of the arithmetic

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/lls16.sv | 22 ++
 rtl/fpu_norm_ls16.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants and the leading-zero priority encoder used by the
// normalizers.
package fpu_pkg;

    localparam int MANT_W  = 16;
    localparam int SHAMT_W = 5;
    localparam int LZC_W   = 5;

    // Scans upward so the highest set bit is the last one written and wins.
    // An all-zero mantissa reports MANT_W.
    function automatic logic [LZC_W-1:0] lzc16(input logic [MANT_W-1:0] m);
        logic [LZC_W-1:0] n;
        n = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (m[i]) begin
                n = LZC_W'(MANT_W - 1 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lls16.sv
// Combinational logical left shifter, 0..15 positions, zero fill.
// Mirror of the alignment right shifter: mux stages of 1, 2, 4, 8.
module lls16
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] data,
    input  logic [3:0]        shift,
    output logic [MANT_W-1:0] result
);

    logic [MANT_W-1:0] st1;
    logic [MANT_W-1:0] st2;
    logic [MANT_W-1:0] st4;

    always_comb begin
        st1    = shift[0] ? {data[MANT_W-2:0], 1'b0} : data;
        st2    = shift[1] ? {st1[MANT_W-3:0], 2'b0}  : st1;
        st4    = shift[2] ? {st2[MANT_W-5:0], 4'b0}  : st2;
        result = shift[3] ? {st4[MANT_W-9:0], 8'b0}  : st4;
    end

endmodule

// File: rtl/fpu_norm_ls16.sv
// Two-stage left-shift normalizer: S1 counts leading zeros and clamps the
// shift against the exponent, S2 shifts the mantissa and lowers the exponent.
module fpu_norm_ls16
    import fpu_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MANT_W-1:0]  in_mant,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MANT_W-1:0]  out_mant,
    output logic [EXP_W-1:0]   out_exp,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_zero,
    output logic               out_uflow,
    output logic [TAG_W-1:0]   out_tag
);

    // Wide enough that lzc (up to 16) and the exponent compare without wrap.
    localparam int CMP_W = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 1;

    // Handshake: a beat moves when valid && ready. A producer holds valid and
    // data steady until ready; in_ready is combinational from stage state and
    // out_ready, and out_* hold while out_valid && !out_ready.
    logic s2_adv;
    logic in_accept;

    logic               s1_v;
    logic [MANT_W-1:0]  s1_mant;
    logic [EXP_W-1:0]   s1_exp;
    logic [SHAMT_W-1:0] s1_shamt;
    logic               s1_zero;
    logic               s1_uflow;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_v;
    logic [MANT_W-1:0]  s2_mant;
    logic [EXP_W-1:0]   s2_exp;
    logic [SHAMT_W-1:0] s2_shamt;
    logic               s2_zero;
    logic               s2_uflow;
    logic [TAG_W-1:0]   s2_tag;

    logic [LZC_W-1:0]   lzc;
    logic [CMP_W-1:0]   lzc_w;
    logic [CMP_W-1:0]   exp_w;
    logic [CMP_W-1:0]   shamt_w;
    logic               zero_c;
    logic               uflow_c;
    logic [SHAMT_W-1:0] shamt_c;

    logic [MANT_W-1:0]  shifted;
    logic [CMP_W-1:0]   exp_dec;

    assign s2_adv    = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_adv;
    assign in_accept = in_valid && in_ready;

    always_comb begin
        lzc     = lzc16(in_mant);
        lzc_w   = CMP_W'(lzc);
        exp_w   = CMP_W'(in_exp);
        zero_c  = (in_mant == '0);
        uflow_c = !zero_c && (lzc_w > exp_w);
        shamt_w = zero_c ? '0 : (uflow_c ? exp_w : lzc_w);
        shamt_c = SHAMT_W'(shamt_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_shamt <= '0;
            s1_zero  <= 1'b0;
            s1_uflow <= 1'b0;
            s1_tag   <= '0;
        end else if (in_accept) begin
            s1_v     <= 1'b1;
            s1_mant  <= in_mant;
            s1_exp   <= in_exp;
            s1_shamt <= shamt_c;
            s1_zero  <= zero_c;
            s1_uflow <= uflow_c;
            s1_tag   <= in_tag;
        end else if (s2_adv) begin
            s1_v <= 1'b0;
        end
    end

    lls16 u_lls16 (
        .data   (s1_mant),
        .shift  (s1_shamt[3:0]),
        .result (shifted)
    );

    // The clamp keeps shamt <= exp, so this subtraction never goes negative.
    assign exp_dec = CMP_W'(s1_exp) - CMP_W'(s1_shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
            s2_shamt <= '0;
            s2_zero  <= 1'b0;
            s2_uflow <= 1'b0;
            s2_tag   <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_mant  <= shifted;
                s2_exp   <= s1_zero ? '0 : EXP_W'(exp_dec);
                s2_shamt <= s1_shamt;
                s2_zero  <= s1_zero;
                s2_uflow <= s1_uflow;
                s2_tag   <= s1_tag;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_mant  = s2_mant;
    assign out_exp   = s2_exp;
    assign out_shamt = s2_shamt;
    assign out_zero  = s2_zero;
    assign out_uflow = s2_uflow;
    assign out_tag   = s2_tag;

endmodule
